pc_seq: RTL and testbench

- Parametrised program-counter sequencer for the ez8 core fetch stage; successor to the fixed 12-bit PC controller.
- Generates the fetch address and handles goto/call/skip/ret.
- Emits a kill strobe that cancels wrongly-issued instructions in the pipeline.
- Owns a configurable-depth return stack. Reports overflow/underflow distinctly and exposes the stack occupancy.
- Optionally vectors to an interrupt handler.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/call_stack.sv | 57 +++++
 rtl/pc_seq.sv | 183 ++++++++++++++++++
 tb/tb_pc_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants for the pc_seq fetch sequencer.
//   - error codes reported on o_err_code
//   - kill-shift reset value (every slot killed out of reset)
//   - stack_entry_w(): return-stack entry width for a given PC width.
//     The interrupt build (macro PC_SEQ_IRQ_EN) adds one isr flag bit
//     above the address. The entry struct itself is declared in pc_seq,
//     because it depends on the ADDR_W parameter.
package pc_seq_pkg;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OVF     = 2'd1;
  localparam logic [1:0] ERR_ISR_UFL = 2'd3;

  // Every kill-shift bit resets to this value, so the pipeline starts flushed.
  localparam logic KILL_RST_BIT = 1'b1;

  function automatic int stack_entry_w(input int addr_w);
`ifdef PC_SEQ_IRQ_EN
    return addr_w + 1;
`else
    return addr_w;
`endif
  endfunction

endpackage

// File: rtl/call_stack.sv
// call_stack: LIFO return stack with a combinational top-of-stack read.
//   clk        core clock
//   i_reset_n  synchronous active-low reset (clears occupancy only)
//   i_push     write i_wdata onto the stack (ignored when full)
//   i_pop      discard the top entry (ignored when empty)
//   i_wdata    entry to push
//   o_rdata    current top entry (undefined when empty)
//   o_empty    no entries
//   o_full     DEPTH entries
//   o_level    number of entries, 0..DEPTH
module call_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [AW-1:0]    w_top_idx;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_level   = r_level;
  // The top lives one below the write slot; wraps harmlessly when empty.
  assign w_top_idx = r_level[AW-1:0] - AW'(1);
  assign o_rdata   = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_level <= '0;
    end else if (i_push && !o_full) begin
      r_level <= r_level + LVL_W'(1);
    end else if (i_pop && !o_empty) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_reset_n && i_push && !o_full) begin
      r_mem[r_level[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the ez8 fetch stage.
// Handles goto/call/skip/ret, drives a kill strobe for wrongly fetched
// slots, and owns the return stack. Interrupt entry is compiled in only
// when the macro PC_SEQ_IRQ_EN is defined.
//   clk            core clock
//   i_reset_n      synchronous active-low reset (beats pause and stopped)
//   i_pause        hold all state this cycle
//   i_goto         branch request, i_goto_addr target
//   i_call         goto is a call (push return address)
//   i_skip         conditional skip taken: cancel last issued instruction
//   i_ret          return request
//   i_irq          level interrupt request
//   o_irq_ack      one-cycle pulse when an interrupt is taken
//   o_pc_out       current fetch address
//   o_kill         kill strobe (MSB of the kill shift register)
//   o_stopped      sequencer halted, sticky until reset
//   o_error        halted because of a fault, sticky
//   o_err_code     0 none, 1 stack overflow, 3 ret underflow inside ISR
//   o_stack_level  return-stack occupancy
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 8,
  parameter int                KILL_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(4)
) (
  input  logic                         clk,
  input  logic                         i_reset_n,
  input  logic                         i_pause,
  input  logic                         i_goto,
  input  logic [ADDR_W-1:0]            i_goto_addr,
  input  logic                         i_call,
  input  logic                         i_skip,
  input  logic                         i_ret,
  input  logic                         i_irq,
  output logic                         o_irq_ack,
  output logic [ADDR_W-1:0]            o_pc_out,
  output logic                         o_kill,
  output logic                         o_stopped,
  output logic                         o_error,
  output logic [1:0]                   o_err_code,
  output logic [$clog2(STACK_DEPTH):0] o_stack_level
);

  localparam int ENTRY_W = stack_entry_w(ADDR_W);
  localparam logic [KILL_DEPTH-1:0] KILL_MSB_ONLY = {1'b1, {(KILL_DEPTH-1){1'b0}}};

  logic [ADDR_W-1:0]     r_pc;
  logic [KILL_DEPTH-1:0] r_kill_shift;
  logic                  r_stopped;
  logic                  r_error;
  logic [1:0]            r_err_code;
  logic                  r_irq_ack;

  logic w_kill, w_adv;
  logic w_act_skip, w_act_goto, w_act_ret, w_act_irq;
  logic w_push, w_pop, w_empty, w_full, w_in_isr;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;
  logic [ADDR_W-1:0]  w_top_addr;

  assign w_kill = r_kill_shift[KILL_DEPTH-1];
  assign w_adv  = !i_pause && !r_stopped;

  // One action per cycle; each later action is masked by the earlier ones.
  assign w_act_skip = i_skip && !w_kill;
  assign w_act_goto = !w_act_skip && i_goto && !r_kill_shift[0];
  assign w_act_ret  = !w_act_skip && !w_act_goto && i_ret && !w_kill;

  assign w_push = i_reset_n && w_adv && !w_full && ((w_act_goto && i_call) || w_act_irq);
  assign w_pop  = i_reset_n && w_adv && !w_empty && w_act_ret;

`ifdef PC_SEQ_IRQ_EN
  typedef struct packed {
    logic              isr_flag;
    logic [ADDR_W-1:0] addr;
  } stack_entry_t;

  stack_entry_t w_wentry, w_rentry;
  logic         r_in_isr;

  assign w_act_irq  = !w_act_skip && !w_act_goto && !w_act_ret &&
                      i_irq && !r_in_isr && !w_kill;
  // The flag marks the frame an interrupt pushed, so its ret leaves the ISR.
  assign w_wentry   = '{isr_flag: w_act_irq, addr: r_pc};
  assign w_wdata    = w_wentry;
  assign w_rentry   = w_rdata;
  assign w_top_addr = w_rentry.addr;
  assign w_in_isr   = r_in_isr;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_in_isr <= 1'b0;
    end else if (w_push && w_act_irq) begin
      r_in_isr <= 1'b1;
    end else if (w_pop && w_rentry.isr_flag) begin
      r_in_isr <= 1'b0;
    end
  end
`else
  logic w_unused_irq;
  assign w_unused_irq = i_irq;
  assign w_act_irq    = 1'b0;
  assign w_wdata      = r_pc;
  assign w_top_addr   = w_rdata;
  assign w_in_isr     = 1'b0;
`endif

  call_stack #(
    .W     (ENTRY_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_level   (o_stack_level)
  );

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_pc         <= RESET_VEC;
      r_kill_shift <= {KILL_DEPTH{KILL_RST_BIT}};
      r_stopped    <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_irq_ack    <= 1'b0;
    end else begin
      r_irq_ack <= 1'b0;
      if (w_adv) begin
        if (w_act_skip) begin
          r_kill_shift <= KILL_MSB_ONLY;
        end else if (w_act_goto) begin
          r_pc         <= i_goto_addr;
          r_kill_shift <= {r_kill_shift[KILL_DEPTH-2:0], 1'b1};
          if (i_call && w_full) begin
            r_stopped  <= 1'b1;
            r_error    <= 1'b1;
            r_err_code <= ERR_OVF;
          end
        end else if (w_act_ret) begin
          if (w_empty) begin
            // Empty-stack ret is a normal program exit unless inside an ISR.
            r_stopped <= 1'b1;
            if (w_in_isr) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_ISR_UFL;
            end
          end else begin
            r_pc         <= w_top_addr;
            r_kill_shift <= {r_kill_shift[KILL_DEPTH-2:0], 1'b1};
          end
        end else if (w_act_irq) begin
          if (w_full) begin
            r_stopped  <= 1'b1;
            r_error    <= 1'b1;
            r_err_code <= ERR_OVF;
          end else begin
            r_pc         <= IRQ_VEC;
            r_irq_ack    <= 1'b1;
            r_kill_shift <= {r_kill_shift[KILL_DEPTH-2:0], 1'b1};
          end
        end else begin
          r_pc         <= r_pc + ADDR_W'(1);
          r_kill_shift <= {r_kill_shift[KILL_DEPTH-2:0], 1'b0};
        end
      end
    end
  end

  assign o_pc_out   = r_pc;
  assign o_kill     = w_kill;
  assign o_stopped  = r_stopped;
  assign o_error    = r_error;
  assign o_err_code = r_err_code;
  assign o_irq_ack  = r_irq_ack;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed bench for pc_seq (default parameters).
// Each step drives inputs, pushes the state expected after the next clock
// edge into a scoreboard queue, then pops and compares once the DUT has
// updated. The interrupt steps are compiled only with PC_SEQ_IRQ_EN.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        reset_n, pause, go, call, skip, ret, irq;
  logic [11:0] goto_addr;
  logic        irq_ack, kill, stopped, error;
  logic [11:0] pc_out;
  logic [1:0]  err_code;
  logic [3:0]  stack_level;

  always #5 clk = ~clk;

  pc_seq #(
    .ADDR_W      (12),
    .STACK_DEPTH (8),
    .KILL_DEPTH  (2),
    .RESET_VEC   (12'h000),
    .IRQ_VEC     (12'h004)
  ) dut (
    .clk           (clk),
    .i_reset_n     (reset_n),
    .i_pause       (pause),
    .i_goto        (go),
    .i_goto_addr   (goto_addr),
    .i_call        (call),
    .i_skip        (skip),
    .i_ret         (ret),
    .i_irq         (irq),
    .o_irq_ack     (irq_ack),
    .o_pc_out      (pc_out),
    .o_kill        (kill),
    .o_stopped     (stopped),
    .o_error       (error),
    .o_err_code    (err_code),
    .o_stack_level (stack_level)
  );

  typedef struct {
    string       tag;
    logic [11:0] pc;
    logic        kill;
    logic [3:0]  lvl;
    logic        stp;
    logic        er;
    logic [1:0]  ec;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic g, input logic [11:0] a, input logic c,
                     input logic s, input logic r);
    go = g; goto_addr = a; call = c; skip = s; ret = r;
  endtask

  task automatic step(input string tag, input logic [11:0] pc, input logic k,
                      input logic [3:0] lvl, input logic st = 1'b0,
                      input logic er = 1'b0, input logic [1:0] ec = 2'd0,
                      input logic ack = 1'b0);
    exp_t e;
    e.tag = tag; e.pc = pc; e.kill = k; e.lvl = lvl;
    e.stp = st; e.er = er; e.ec = ec; e.ack = ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("[%0t] %s pc=%03h kill=%b lvl=%0d stopped=%b error=%b code=%0d ack=%b",
             $time, e.tag, pc_out, kill, stack_level, stopped, error, err_code, irq_ack);
    chk({e.tag, ".pc"},      16'(pc_out),      16'(e.pc));
    chk({e.tag, ".kill"},    16'(kill),        16'(e.kill));
    chk({e.tag, ".level"},   16'(stack_level), 16'(e.lvl));
    chk({e.tag, ".stopped"}, 16'(stopped),     16'(e.stp));
    chk({e.tag, ".error"},   16'(error),       16'(e.er));
    chk({e.tag, ".code"},    16'(err_code),    16'(e.ec));
    chk({e.tag, ".ack"},     16'(irq_ack),     16'(e.ack));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; pause = 1'b0; irq = 1'b0;
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

    // Reset and free run: kill covers the first two fetches.
    step("reset", 12'h000, 1'b1, 4'd0);
    reset_n = 1'b1;
    step("run1", 12'h001, 1'b1, 4'd0);
    step("run2", 12'h002, 1'b0, 4'd0);
    step("run3", 12'h003, 1'b0, 4'd0);
    step("run4", 12'h004, 1'b0, 4'd0);

    // Reach pc=0x012 with kill_shift[0]=0, then call 0x100 and return.
    drv(1'b1, 12'h011, 1'b0, 1'b0, 1'b0); step("goto011", 12'h011, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("slot012", 12'h012, 1'b1, 4'd0);
    drv(1'b1, 12'h100, 1'b1, 1'b0, 1'b0); step("call100", 12'h100, 1'b0, 4'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("slot101", 12'h101, 1'b1, 4'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("ret_killed", 12'h102, 1'b0, 4'd1);
    step("ret", 12'h012, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("run013", 12'h013, 1'b1, 4'd0);
    step("run014", 12'h014, 1'b0, 4'd0);

    // Skip beats goto; pause drops a goto.
    drv(1'b1, 12'h200, 1'b0, 1'b1, 1'b0); step("skip_wins", 12'h014, 1'b1, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("after_skip", 12'h015, 1'b0, 4'd0);
    pause = 1'b1;
    drv(1'b1, 12'h300, 1'b0, 1'b0, 1'b0); step("pause_hold", 12'h015, 1'b0, 4'd0);
    pause = 1'b0;
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("after_pause", 12'h016, 1'b0, 4'd0);

    // ret on an empty stack: clean stop, pc holds, later requests dropped.
    drv(1'b1, 12'h020, 1'b0, 1'b0, 1'b0); step("goto020", 12'h020, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("ret_empty", 12'h020, 1'b0, 4'd0, 1'b1);
    drv(1'b1, 12'h333, 1'b1, 1'b0, 1'b0); step("stopped_drop", 12'h020, 1'b0, 4'd0, 1'b1);

    // Nine nested calls: the ninth overflows an 8-deep stack.
    reset_n = 1'b0;
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("reset2", 12'h000, 1'b1, 4'd0);
    reset_n = 1'b1;
    step("run_b", 12'h001, 1'b1, 4'd0);
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, 12'h400 + 12'(16 * i), 1'b1, 1'b0, 1'b0);
      if (i < 8) begin
        step($sformatf("call%0d", i), 12'h400 + 12'(16 * i), 1'b0, 4'(i + 1));
        drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        step($sformatf("gap%0d", i), 12'h401 + 12'(16 * i), 1'b1, 4'(i + 1));
      end else begin
        step("call_ovf", 12'h480, 1'b0, 4'd8, 1'b1, 1'b1, 2'd1);
      end
    end
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("ovf_hold", 12'h480, 1'b0, 4'd8, 1'b1, 1'b1, 2'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("ovf_ret_drop", 12'h480, 1'b0, 4'd8, 1'b1, 1'b1, 2'd1);

    // Two-deep nest unwinds in LIFO order, then the pc wraps.
    reset_n = 1'b0;
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("reset3", 12'h000, 1'b1, 4'd0);
    reset_n = 1'b1;
    step("run_c", 12'h001, 1'b1, 4'd0);
    drv(1'b1, 12'h500, 1'b1, 1'b0, 1'b0); step("call500", 12'h500, 1'b0, 4'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("slot501", 12'h501, 1'b1, 4'd1);
    drv(1'b1, 12'h600, 1'b1, 1'b0, 1'b0); step("call600", 12'h600, 1'b0, 4'd2);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("pop_inner", 12'h501, 1'b1, 4'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("run502", 12'h502, 1'b1, 4'd1);
    step("run503", 12'h503, 1'b0, 4'd1);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("pop_outer", 12'h001, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("run002", 12'h002, 1'b1, 4'd0);
    drv(1'b1, 12'hfff, 1'b0, 1'b0, 1'b0); step("gotofff", 12'hfff, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0); step("wrap", 12'h000, 1'b1, 4'd0);

`ifdef PC_SEQ_IRQ_EN
    // Interrupt entry, no nesting, return clears the ISR state.
    drv(1'b1, 12'h050, 1'b0, 1'b0, 1'b0); step("goto050", 12'h050, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    irq = 1'b1; step("irq_take", 12'h004, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 1'b1);
    step("irq_nested", 12'h005, 1'b1, 4'd1);
    step("irq_nested2", 12'h006, 1'b0, 4'd1);
    irq = 1'b0;
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b1); step("isr_ret", 12'h050, 1'b0, 4'd0);
    drv(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    irq = 1'b1; step("irq_again", 12'h004, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 1'b1);
    irq = 1'b0; step("isr_run", 12'h005, 1'b1, 4'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
